mac_rx_frame_ctrl: RTL



---
 rtl/mac_rx_ctrl_pkg.sv | 6 +
 rtl/mac_rx_frame_ram.sv | 21 ++
 rtl/mac_rx_frame_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mac_rx_ctrl_pkg.sv
// mac_rx_ctrl_pkg: shared types and widths for the MAC receive frame buffer.
package mac_rx_ctrl_pkg;
    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
    localparam int ENTRY_W = 73;
    localparam int CNT_W = 32;
endpackage

// File: rtl/mac_rx_frame_ram.sv
// mac_rx_frame_ram: simple dual-port packet RAM, one write port and one registered read port.
module mac_rx_frame_ram
    import mac_rx_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic               rx_clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);
    logic [ENTRY_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge rx_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mac_rx_frame_ctrl.sv
// mac_rx_frame_ctrl: commits CRC-good MAC frames into a packet RAM and streams them to the user.
// Frame counters exist only when MAC_RX_FRAME_CTRL_STATS_EN is defined; otherwise they read 0.
module mac_rx_frame_ctrl
    import mac_rx_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 1200
) (
    input  logic             rx_clk,
    input  logic             reset,
    input  logic [63:0]      mac_data,
    input  logic [7:0]       mac_data_valid,
    input  logic             mac_good_frame,
    input  logic             mac_bad_frame,
    output logic [63:0]      usr_data,
    output logic [7:0]       usr_keep,
    output logic             usr_last,
    output logic             usr_valid,
    input  logic             usr_ready,
    output logic [CNT_W-1:0] frame_good_cnt,
    output logic [CNT_W-1:0] frame_bad_cnt,
    output logic [CNT_W-1:0] frame_drop_cnt
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    w_state_t state, state_nx;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
    logic [63:0] stg_data;
    logic [7:0] stg_keep;
    logic stg_v;
    logic [CW-1:0] cnt;
    logic dv, strobe, full, empty;
    logic we, wlast, load, commit, rollback;
    logic ren, out_load, ram_v;
    logic [ENTRY_W-1:0] ram_q;

    assign dv = |mac_data_valid;
    assign strobe = mac_good_frame | mac_bad_frame;
    assign full = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty = rd_ptr == commit_ptr;

    always_comb begin
        state_nx = state;
        we = 1'b0;
        wlast = 1'b0;
        load = 1'b0;
        commit = 1'b0;
        rollback = 1'b0;
        case (state)
            W_IDLE: if (dv) begin
                load = 1'b1;
                state_nx = W_FRAME;
            end
            W_FRAME: if (dv && strobe) begin
                rollback = 1'b1;
                state_nx = W_IDLE;
            end else if (dv) begin
                if (full || cnt == CW'(MAX_WORDS)) begin
                    rollback = 1'b1;
                    state_nx = W_DROP;
                end else begin
                    we = stg_v;
                    load = 1'b1;
                end
            end else if (mac_good_frame) begin
                // a frame that exactly fills the RAM has no room left for its final word
                rollback = full;
                we = !full;
                wlast = 1'b1;
                commit = !full;
                state_nx = W_IDLE;
            end else if (mac_bad_frame) begin
                rollback = 1'b1;
                state_nx = W_IDLE;
            end
            W_DROP: if (strobe) state_nx = W_IDLE;
            default: state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state <= W_IDLE;
            wr_ptr <= '0;
            commit_ptr <= '0;
            stg_v <= 1'b0;
            stg_data <= '0;
            stg_keep <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            wr_ptr <= rollback ? commit_ptr : wr_ptr + {{ADDR_W{1'b0}}, we};
            if (commit) commit_ptr <= wr_ptr + 1'b1;
            stg_v <= load || (stg_v && state_nx == W_FRAME);
            if (load) begin
                stg_data <= mac_data;
                stg_keep <= mac_data_valid;
                cnt <= state == W_IDLE ? CW'(1) : cnt + 1'b1;
            end
        end
    end

    mac_rx_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
        .rx_clk(rx_clk),
        .we(we),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata({wlast, stg_keep, stg_data}),
        .re(ren),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(ram_q)
    );

    // RAM output register feeds the user register, prefetching whenever the next stage frees up
    assign out_load = ram_v && (!usr_valid || usr_ready);
    assign ren = !empty && (!ram_v || out_load);

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            rd_ptr <= '0;
            ram_v <= 1'b0;
            usr_valid <= 1'b0;
            usr_last <= 1'b0;
            usr_keep <= '0;
            usr_data <= '0;
        end else begin
            if (ren) rd_ptr <= rd_ptr + 1'b1;
            ram_v <= ren || (ram_v && !out_load);
            usr_valid <= out_load || (usr_valid && !usr_ready);
            if (out_load) {usr_last, usr_keep, usr_data} <= ram_q;
        end
    end

`ifdef MAC_RX_FRAME_CTRL_STATS_EN
    logic good_inc, bad_inc, drop_inc;
    assign good_inc = commit;
    assign bad_inc = state == W_FRAME && !dv && !mac_good_frame && mac_bad_frame;
    assign drop_inc = state == W_DROP ? strobe : state == W_FRAME && (dv ? strobe : mac_good_frame && full);

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            frame_good_cnt <= '0;
            frame_bad_cnt <= '0;
            frame_drop_cnt <= '0;
        end else begin
            frame_good_cnt <= frame_good_cnt + {{(CNT_W-1){1'b0}}, good_inc};
            frame_bad_cnt <= frame_bad_cnt + {{(CNT_W-1){1'b0}}, bad_inc};
            frame_drop_cnt <= frame_drop_cnt + {{(CNT_W-1){1'b0}}, drop_inc};
        end
    end
`else
    assign frame_good_cnt = '0;
    assign frame_bad_cnt = '0;
    assign frame_drop_cnt = '0;
`endif
endmodule
